// File: rtl/graph_mem_sequencer_if.sv
// Memory read bus plus local buffer write port of graph_mem_sequencer.
// The sequencer is the master; the memory and buffers sit behind the slave modport.
interface graph_mem_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              vtx_we;
  logic              edge_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0] buf_wdata;

  modport master (
    output mem_req, mem_sel, mem_addr, vtx_we, edge_we, buf_waddr, buf_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_sel, mem_addr, vtx_we, edge_we, buf_waddr, buf_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/graph_mem_sequencer.sv
// Fetches the whole vertex table, then the whole edge table, into local buffers.
// Optional macro GRAPH_ROVER_CMD_EN adds rover movement outputs decoded from vertex words.
//
// Handshake: mem_req stays high with mem_addr/mem_sel stable until a cycle where
// mem_ack=1; that cycle transfers mem_rdata. mem_ack is ignored while mem_req=0.
module graph_mem_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_trigger,
  input  logic                  abort,
  graph_mem_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
`ifdef GRAPH_ROVER_CMD_EN
  ,
  output logic                  rover_forward,
  output logic                  rover_backward,
  output logic                  rover_left,
  output logic                  rover_right
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VTX_REQ  = 2'd1,
    EDGE_REQ = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              vtx_we_q, vtx_we_d;
  logic              edge_we_q, edge_we_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      vtx_we_q  <= 1'b0;
      edge_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      vtx_we_q  <= vtx_we_d;
      edge_we_q <= edge_we_d;
    end
  end

  // Abort is checked before mem_ack so an ack landing in the abort cycle is dropped.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    vtx_we_d  = 1'b0;
    edge_we_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!abort && start_trigger) begin
          state_d = VTX_REQ;
          addr_d  = '0;
        end
      end
      VTX_REQ: begin
        if (abort) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (bus.mem_ack) begin
          vtx_we_d = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = bus.mem_rdata;
          addr_d   = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = EDGE_REQ;
        end
      end
      EDGE_REQ: begin
        if (abort) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (bus.mem_ack) begin
          edge_we_d = 1'b1;
          waddr_d   = addr_q;
          wdata_d   = bus.mem_rdata;
          addr_d    = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = (state_q == VTX_REQ) || (state_q == EDGE_REQ);
  assign bus.mem_sel   = (state_q == EDGE_REQ);
  assign bus.mem_addr  = addr_q;
  assign bus.vtx_we    = vtx_we_q;
  assign bus.edge_we   = edge_we_q;
  assign bus.buf_waddr = waddr_q;
  assign bus.buf_wdata = wdata_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign state_dbg     = state_q;

`ifdef GRAPH_ROVER_CMD_EN
  logic fwd_q, fwd_d;
  logic bwd_q, bwd_d;
  logic left_q, left_d;
  logic right_q, right_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_q   <= 1'b0;
      bwd_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      fwd_q   <= fwd_d;
      bwd_q   <= bwd_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Unknown command words leave the current movement in place.
  always_comb begin
    fwd_d   = fwd_q;
    bwd_d   = bwd_q;
    left_d  = left_q;
    right_d = right_q;
    if (vtx_we_q) begin
      if (wdata_q == DATA_W'(1)) begin
        {fwd_d, bwd_d, left_d, right_d} = 4'b1010;
      end else if (wdata_q == DATA_W'(2)) begin
        {fwd_d, bwd_d, left_d, right_d} = 4'b0100;
      end else if (wdata_q == DATA_W'(3)) begin
        {fwd_d, bwd_d, left_d, right_d} = 4'b1001;
      end else if (wdata_q == DATA_W'(0)) begin
        {fwd_d, bwd_d, left_d, right_d} = 4'b0000;
      end
    end
  end

  assign rover_forward  = fwd_q;
  assign rover_backward = bwd_q;
  assign rover_left     = left_q;
  assign rover_right    = right_q;
`endif

endmodule

// File: tb/tb_graph_mem_sequencer.sv
// Directed bench for graph_mem_sequencer with 4-word tables (ADDR_W=2).
// Rover checks are included when GRAPH_ROVER_CMD_EN is defined.
module tb_graph_mem_sequencer;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int W      = 1 + ADDR_W + DATA_W;

  logic       clk;
  logic       reset_n;
  logic       start_trigger;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;
`ifdef GRAPH_ROVER_CMD_EN
  logic       rf, rb, rl, rr;
`endif

  graph_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  graph_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_trigger (start_trigger),
    .abort         (abort),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
`ifdef GRAPH_ROVER_CMD_EN
    ,
    .rover_forward (rf),
    .rover_backward(rb),
    .rover_left    (rl),
    .rover_right   (rr)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents and hand-derived expectations
  logic [DATA_W-1:0] vtx_tbl [4] = '{8'h01, 8'h7F, 8'h02, 8'h00};
  logic [DATA_W-1:0] edge_tbl[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [3:0]        exp_rover[4] = '{4'b1010, 4'b1010, 4'b0100, 4'b0000};

  logic [W-1:0] exp_q[$];
  int n_cmp, n_bad;
  int vtx_cnt, edge_cnt, done_cnt, stall_cnt, act_cnt, wait_cnt;
  logic ack_prev, abort_prev, rov_pending;
  logic [ADDR_W-1:0] rov_idx;
  logic start_pulse, start_mid_arm, abort_pulse, abort_arm, stray_ack;
  logic slow_en;
  logic [ADDR_W-1:0] slow_addr;
  int slow_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input logic sel);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_strobe", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(sel ? "edge_strobe" : "vtx_strobe",
            32'({sel, bus.buf_waddr, bus.buf_wdata}), 32'(e));
    end
  endtask

  task automatic push_pass(input int nv, input int ne);
    for (int i = 0; i < nv; i++) exp_q.push_back({1'b0, ADDR_W'(i), vtx_tbl[i]});
    for (int i = 0; i < ne; i++) exp_q.push_back({1'b1, ADDR_W'(i), edge_tbl[i]});
  endtask

  // One clock: observe what the last posedge produced, then drive the next inputs.
  task automatic tick();
    logic strobe, ack, ab, st;
    int delay;
    @(negedge clk);
    strobe = bus.vtx_we | bus.edge_we;
    check("strobe_timing", 32'(strobe), 32'(ack_prev & ~abort_prev));
    if (bus.vtx_we) begin vtx_cnt++; sb_pop(1'b0); end
    if (bus.edge_we) begin edge_cnt++; sb_pop(1'b1); end
`ifdef GRAPH_ROVER_CMD_EN
    if (rov_pending) check("rover", 32'({rf, rb, rl, rr}), 32'(exp_rover[rov_idx]));
    rov_pending = bus.vtx_we;
    rov_idx     = bus.buf_waddr;
`endif
    if (done) done_cnt++;
    if (bus.mem_req || busy || strobe || done) act_cnt++;

    delay = (slow_en && bus.mem_req && !bus.mem_sel && bus.mem_addr == slow_addr) ? slow_delay : 0;
    ack = bus.mem_req && (wait_cnt >= delay);
    wait_cnt = (bus.mem_req && !ack) ? wait_cnt + 1 : 0;
    if (bus.mem_req && !ack && !bus.mem_sel && bus.mem_addr == 2'd1) stall_cnt++;
    ab = abort_pulse || (abort_arm && bus.mem_req && bus.mem_sel && bus.mem_addr == 2'd2);
    if (ab) begin abort_pulse = 1'b0; abort_arm = 1'b0; end
    st = start_pulse || (start_mid_arm && bus.mem_req && !bus.mem_sel && bus.mem_addr == 2'd2);
    if (st) begin start_pulse = 1'b0; start_mid_arm = 1'b0; end
    bus.mem_ack   = ack || (stray_ack && !bus.mem_req);
    bus.mem_rdata = ack ? (bus.mem_sel ? edge_tbl[bus.mem_addr] : vtx_tbl[bus.mem_addr])
                        : DATA_W'($urandom_range(0, 255));
    abort         = ab;
    start_trigger = st;
    ack_prev      = ack;
    abort_prev    = ab;
  endtask

  task automatic clear_counts();
    vtx_cnt = 0; edge_cnt = 0; done_cnt = 0; stall_cnt = 0; act_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
`ifdef GRAPH_ROVER_CMD_EN
    check({tag, "_rover"}, 32'({rf, rb, rl, rr}), 32'd0);
`endif
    check({tag, "_ctrl"}, 32'({bus.mem_req, bus.mem_sel, bus.vtx_we, bus.edge_we, busy, done, state_dbg}), 32'd0);
    check({tag, "_addr"}, 32'({bus.mem_addr, bus.buf_waddr}), 32'd0);
    check({tag, "_wdata"}, 32'(bus.buf_wdata), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.mem_ack = 1'b0;
    start_trigger = 1'b0;
    abort = 1'b0;
    ack_prev = 1'b0; abort_prev = 1'b0; rov_pending = 1'b0; wait_cnt = 0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Starts a pass and runs until done; then confirms busy drops the next cycle.
  task automatic run_pass(input string tag);
    int d0;
    logic seen;
    d0 = done_cnt;
    seen = 1'b0;
    start_pulse = 1'b1;
    tick();
    tick();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (done_cnt != d0) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick();
    check({tag, "_idle_after_done"}, 32'({busy, done, bus.mem_req}), 32'd0);
  endtask

  initial begin
    logic found;
    n_cmp = 0; n_bad = 0;
    start_pulse = 0; start_mid_arm = 0; abort_pulse = 0; abort_arm = 0; stray_ack = 0;
    slow_en = 0; slow_addr = '0; slow_delay = 0;
    bus.mem_rdata = '0;
    clear_counts();
    apply_reset();

    // Full pass, ack every cycle
    clear_counts();
    push_pass(4, 4);
    run_pass("full");
    check("full_counts", 32'({8'(vtx_cnt), 8'(edge_cnt), 8'(done_cnt)}), 32'h00040401);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Ack delayed 5 cycles at vertex address 1
    clear_counts();
    slow_en = 1'b1; slow_addr = 2'd1; slow_delay = 5;
    push_pass(4, 4);
    run_pass("slow");
    slow_en = 1'b0;
    check("slow_stall_cycles", 32'(stall_cnt), 32'd5);
    check("slow_counts", 32'({8'(vtx_cnt), 8'(edge_cnt), 8'(done_cnt)}), 32'h00040401);
    check("slow_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort coincident with ack at edge address 2
    clear_counts();
    push_pass(4, 2);
    abort_arm = 1'b1;
    start_pulse = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (abort_prev) found = 1'b1;
    end
    check("abort_fired", 32'(found), 32'd1);
    tick();
    check("abort_next_state", 32'({state_dbg, bus.mem_req, busy}), 32'd0);
    repeat (4) tick();
    check("abort_counts", 32'({8'(vtx_cnt), 8'(edge_cnt), 8'(done_cnt)}), 32'h00040200);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort beats start in IDLE
    clear_counts();
    start_pulse = 1'b1; abort_pulse = 1'b1;
    repeat (4) tick();
    check("abort_vs_start_activity", 32'(act_cnt), 32'd0);

    // Start pulsed mid-pass is ignored
    clear_counts();
    push_pass(4, 4);
    start_mid_arm = 1'b1;
    run_pass("restart");
    check("restart_mid_start_fired", 32'(start_mid_arm), 32'd0);
    repeat (4) tick();
    check("restart_counts", 32'({8'(vtx_cnt), 8'(edge_cnt), 8'(done_cnt)}), 32'h00040401);
    check("restart_sb_empty", 32'(exp_q.size()), 32'd0);
    check("restart_idle", 32'({bus.mem_req, busy}), 32'd0);

    // Reset mid vertex read, then silence with stray acks until a new start
    clear_counts();
    push_pass(4, 4);
    start_pulse = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus.mem_req && !bus.mem_sel && bus.mem_addr == 2'd2) found = 1'b1;
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    bus.mem_ack = 1'b0;
    ack_prev = 1'b0; abort_prev = 1'b0; rov_pending = 1'b0; wait_cnt = 0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    clear_counts();
    stray_ack = 1'b1;
    repeat (10) tick();
    stray_ack = 1'b0;
    tick();
    check("post_reset_quiet", 32'(act_cnt), 32'd0);

    // Recovery pass after reset
    clear_counts();
    push_pass(4, 4);
    run_pass("recover");
    check("recover_counts", 32'({8'(vtx_cnt), 8'(edge_cnt), 8'(done_cnt)}), 32'h00040401);
    check("recover_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
